// File: rtl/bg_write_arbiter_pkg.sv
// bg_write_arbiter_pkg: shared widths, request field offsets and helpers for the bank-group write arbiter
package bg_write_arbiter_pkg;
   localparam int W_Q      = 35;
   localparam int W_D      = 33;
   localparam int NUM_LSU  = 4;
   localparam int NUM_BG   = 4;
   localparam int SEL_LSB  = 33;
   localparam int WEN_BIT  = 32;
   localparam int DATA_W   = 32;
   localparam int CNT_W    = 16;

   // Two or more requesters on one bank group is a conflict.
   function automatic logic is_conflict(input logic [NUM_LSU-1:0] v);
      return $countones(v) > 1;
   endfunction
endpackage

// File: rtl/bg_write_arbiter_rr.sv
// rr_arbiter_4: four-way round-robin arbiter for one bank group
//   req     in  4 : valid requesters targeting this bank group
//   ptr     in  2 : current highest-priority requester
//   stall   in  1 : blocks any grant this cycle
//   gnt     out 4 : one-hot grant (all zero when nothing granted)
//   ptr_nxt out 2 : winner+1, or ptr unchanged when nothing granted
module rr_arbiter_4
   import bg_write_arbiter_pkg::*;
(
   input  logic [NUM_LSU-1:0] req,
   input  logic [1:0]         ptr,
   input  logic               stall,
   output logic [NUM_LSU-1:0] gnt,
   output logic [1:0]         ptr_nxt
);
   logic [1:0] idx;
   // Scan from lowest to highest priority so the highest-priority hit is written last.
   always_comb begin
      gnt     = '0;
      ptr_nxt = ptr;
      idx     = '0;
      for (int j = NUM_LSU - 1; j >= 0; j--) begin
         idx = ptr + 2'(j);
         if (req[idx] && !stall) begin
            gnt     = 4'b0001 << idx;
            ptr_nxt = idx + 2'd1;
         end
      end
   end
endmodule

// File: rtl/bg_write_arbiter.sv
// bg_write_arbiter: per-bank-group round-robin write arbiter with registered bank-group ports
//   clk, rst                 : clock, asynchronous active-high reset
//   LSU_W_req_0..3  in  35   : {sel[1:0], wen, data[31:0]}
//   LSU_W_ready_0..3 out 1   : same-cycle grant to each LSU
//   bg_stall        in  4    : per-bank-group grant block
//   W_BG_0..3       out 33   : registered {wen, data} per bank group
//   perf_clr        in  1    : counter clear   (BG_WRITE_ARB_PERF_CNT_EN only)
//   bg_conflict_cnt out 64   : 4x16 conflict counters (BG_WRITE_ARB_PERF_CNT_EN only)
module bg_write_arbiter
   import bg_write_arbiter_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic [W_Q-1:0]   LSU_W_req_0,
   input  logic [W_Q-1:0]   LSU_W_req_1,
   input  logic [W_Q-1:0]   LSU_W_req_2,
   input  logic [W_Q-1:0]   LSU_W_req_3,
   output logic             LSU_W_ready_0,
   output logic             LSU_W_ready_1,
   output logic             LSU_W_ready_2,
   output logic             LSU_W_ready_3,
   input  logic [NUM_BG-1:0] bg_stall,
   output logic [W_D-1:0]   W_BG_0,
   output logic [W_D-1:0]   W_BG_1,
   output logic [W_D-1:0]   W_BG_2,
   output logic [W_D-1:0]   W_BG_3
`ifdef BG_WRITE_ARB_PERF_CNT_EN
   ,
   input  logic             perf_clr,
   output logic [63:0]      bg_conflict_cnt
`endif
);
   logic [W_Q-1:0]     req     [NUM_LSU];
   logic [NUM_LSU-1:0] bg_req  [NUM_BG];
   logic [NUM_LSU-1:0] gnt     [NUM_BG];
   logic [1:0]         ptr     [NUM_BG];
   logic [1:0]         ptr_nxt [NUM_BG];
   logic [W_D-1:0]     w_bg    [NUM_BG];
   logic [W_D-1:0]     w_bg_d  [NUM_BG];
   logic [NUM_LSU-1:0] ready;

   assign req = '{LSU_W_req_0, LSU_W_req_1, LSU_W_req_2, LSU_W_req_3};

   always_comb begin
      for (int b = 0; b < NUM_BG; b++) begin
         bg_req[b] = '0;
         for (int i = 0; i < NUM_LSU; i++)
            bg_req[b][i] = req[i][WEN_BIT] && (req[i][SEL_LSB +: 2] == 2'(b));
      end
   end

   for (genvar g = 0; g < NUM_BG; g++) begin : g_arb
      rr_arbiter_4 u_arb (
         .req     (bg_req[g]),
         .ptr     (ptr[g]),
         .stall   (bg_stall[g]),
         .gnt     (gnt[g]),
         .ptr_nxt (ptr_nxt[g])
      );
   end

   // Grants are one-hot per bank group, so an OR-mux selects the winner's data.
   always_comb begin
      ready = '0;
      for (int b = 0; b < NUM_BG; b++) begin
         w_bg_d[b] = '0;
         for (int i = 0; i < NUM_LSU; i++)
            w_bg_d[b] = w_bg_d[b] | ({W_D{gnt[b][i]}} & {1'b1, req[i][DATA_W-1:0]});
         ready = ready | gnt[b];
      end
   end

   assign {LSU_W_ready_3, LSU_W_ready_2, LSU_W_ready_1, LSU_W_ready_0} = rst ? '0 : ready;
   assign {W_BG_0, W_BG_1, W_BG_2, W_BG_3} = {w_bg[0], w_bg[1], w_bg[2], w_bg[3]};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int b = 0; b < NUM_BG; b++) begin
            ptr[b]  <= '0;
            w_bg[b] <= '0;
         end
      end else begin
         for (int b = 0; b < NUM_BG; b++) begin
            ptr[b]  <= ptr_nxt[b];
            w_bg[b] <= w_bg_d[b];
         end
      end
   end

`ifdef BG_WRITE_ARB_PERF_CNT_EN
   logic [CNT_W-1:0] cnt [NUM_BG];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int b = 0; b < NUM_BG; b++) cnt[b] <= '0;
      end else if (perf_clr) begin
         for (int b = 0; b < NUM_BG; b++) cnt[b] <= '0;
      end else begin
         for (int b = 0; b < NUM_BG; b++)
            if (is_conflict(bg_req[b]) && cnt[b] != '1) cnt[b] <= cnt[b] + 1'b1;
      end
   end

   assign bg_conflict_cnt = {cnt[3], cnt[2], cnt[1], cnt[0]};
`endif
endmodule

// File: tb/tb_bg_write_arbiter.sv
// tb_bg_write_arbiter: directed plus random checks of bg_write_arbiter against a behavioural model
module tb_bg_write_arbiter;
   logic        clk = 0;
   logic        rst;
   logic [34:0] rq [4];
   logic [3:0]  rdy;
   logic [3:0]  stall;
   logic [32:0] wbg [4];
`ifdef BG_WRITE_ARB_PERF_CNT_EN
   logic        perf_clr;
   logic [63:0] cnt_o;
   int          m_cnt [4];
`endif

   int          n_cmp = 0;
   int          n_err = 0;
   int          m_p [4];
   logic [32:0] m_w [4];
   logic [3:0]  gr;

   always #5 clk = ~clk;

   bg_write_arbiter dut (
      .clk(clk), .rst(rst),
      .LSU_W_req_0(rq[0]), .LSU_W_req_1(rq[1]), .LSU_W_req_2(rq[2]), .LSU_W_req_3(rq[3]),
      .LSU_W_ready_0(rdy[0]), .LSU_W_ready_1(rdy[1]), .LSU_W_ready_2(rdy[2]), .LSU_W_ready_3(rdy[3]),
      .bg_stall(stall),
      .W_BG_0(wbg[0]), .W_BG_1(wbg[1]), .W_BG_2(wbg[2]), .W_BG_3(wbg[3])
`ifdef BG_WRITE_ARB_PERF_CNT_EN
      , .perf_clr(perf_clr), .bg_conflict_cnt(cnt_o)
`endif
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [34:0] mk(input int sel, input logic [31:0] d);
      return {2'(sel), 1'b1, d};
   endfunction

   task automatic model_reset();
      for (int b = 0; b < 4; b++) begin
         m_p[b] = 0;
         m_w[b] = '0;
`ifdef BG_WRITE_ARB_PERF_CNT_EN
         m_cnt[b] = 0;
`endif
      end
   endtask

   // One clock cycle: compare ready and outputs mid-cycle, then advance the model.
   task automatic cycle();
      int win;
      int nreq;
      logic [3:0] er;
      @(negedge clk);
      er = '0;
      for (int b = 0; b < 4; b++) begin
         chk($sformatf("wbg%0d", b), {31'b0, wbg[b]}, {31'b0, m_w[b]});
`ifdef BG_WRITE_ARB_PERF_CNT_EN
         chk($sformatf("cnt%0d", b), {48'b0, cnt_o[16*b +: 16]}, 64'(m_cnt[b]));
`endif
         win = -1;
         nreq = 0;
         for (int j = 0; j < 4; j++) begin
            int k = (m_p[b] + j) % 4;
            if (rq[k][32] && int'(rq[k][34:33]) == b) begin
               nreq++;
               if (win < 0 && !stall[b]) win = k;
            end
         end
         if (win >= 0) begin
            er[win] = 1'b1;
            m_w[b] = {1'b1, rq[win][31:0]};
            m_p[b] = (win + 1) % 4;
         end else m_w[b] = '0;
`ifdef BG_WRITE_ARB_PERF_CNT_EN
         if (perf_clr) m_cnt[b] = 0;
         else if (nreq >= 2 && m_cnt[b] < 65535) m_cnt[b]++;
`endif
      end
      chk("ready", {60'b0, rdy}, {60'b0, er});
      gr = er;
      @(posedge clk);
      #1;
   endtask

   task automatic drop_granted();
      for (int i = 0; i < 4; i++) if (gr[i]) rq[i] = '0;
   endtask

   initial begin
      rst = 1;
      stall = '0;
      for (int i = 0; i < 4; i++) rq[i] = '0;
`ifdef BG_WRITE_ARB_PERF_CNT_EN
      perf_clr = 0;
`endif
      model_reset();
      rq[0] = mk(0, 32'h1111_1111);
      #2;
      chk("rst_ready", {60'b0, rdy}, 64'h0);
      for (int b = 0; b < 4; b++) chk($sformatf("rst_wbg%0d", b), {31'b0, wbg[b]}, 64'h0);
      rq[0] = '0;
      repeat (2) @(posedge clk);
      #1 rst = 0;

      // Single write to bank group 2.
      rq[0] = mk(2, 32'hA5A5_A5A5);
      cycle();
      chk("t1_ready0", {63'b0, gr[0]}, 64'h1);
      chk("t1_wbg2", {31'b0, wbg[2]}, 64'h1_A5A5_A5A5);
      chk("t1_wbg0", {31'b0, wbg[0]}, 64'h0);
      drop_granted();
      cycle();

      // Everyone on bank group 1, holding until granted.
      for (int i = 0; i < 4; i++) rq[i] = mk(1, 32'hB000_0000 + 32'(i));
      for (int n = 0; n < 4; n++) begin
         cycle();
         chk($sformatf("t2_order%0d", n), {31'b0, wbg[1]}, {31'b0, 1'b1, 32'hB000_0000 + 32'(n)});
         drop_granted();
      end
      chk("t2_p1", 64'(m_p[1]), 64'h0);

      // Disjoint targets: four grants in one cycle.
      for (int i = 0; i < 4; i++) rq[i] = mk(3 - i, 32'hC000_0000 + 32'(i));
      cycle();
      chk("t3_ready", {60'b0, gr}, 64'hF);
      for (int b = 0; b < 4; b++) chk($sformatf("t3_wbg%0d", b), {31'b0, wbg[b]}, {31'b0, 1'b1, 32'hC000_0000 + 32'(3 - b)});
      drop_granted();

      // Stalled bank group 0 for three cycles.
      stall = 4'b0001;
      rq[2] = mk(0, 32'hD00D_0002);
      repeat (3) cycle();
      stall = '0;
      cycle();
      chk("t4_grant", {63'b0, gr[2]}, 64'h1);
      drop_granted();
      cycle();
      chk("t4_wbg0", {31'b0, wbg[0]}, 64'h0);

      // Reset right after a grant clears outputs and pointers.
      rq[1] = mk(0, 32'hE000_0001);
      cycle();
      drop_granted();
      chk("t5_pre", {31'b0, wbg[0]}, 64'h1_E000_0001);
      rst = 1;
      #1;
      for (int b = 0; b < 4; b++) chk($sformatf("t5_wbg%0d", b), {31'b0, wbg[b]}, 64'h0);
      chk("t5_ready", {60'b0, rdy}, 64'h0);
      model_reset();
      @(posedge clk);
      #1 rst = 0;
      rq[0] = mk(0, 32'hE000_0000);
      rq[3] = mk(0, 32'hE000_0003);
      cycle();
      chk("t5_lsu0_first", {31'b0, wbg[0]}, 64'h1_E000_0000);
      drop_granted();
      cycle();
      drop_granted();

`ifdef BG_WRITE_ARB_PERF_CNT_EN
      for (int i = 0; i < 4; i++) rq[i] = '0;
      rq[0] = mk(3, 32'hF000_0000);
      rq[1] = mk(3, 32'hF000_0001);
      stall = 4'b1000;
      repeat (5) cycle();
      chk("t6_cnt5", {48'b0, cnt_o[63:48]}, 64'h5);
      repeat (65534 - 5) @(posedge clk);
      #1;
      m_cnt[3] = 65534;
      for (int b = 0; b < 4; b++) m_w[b] = '0;
      chk("t6_fffe", {48'b0, cnt_o[63:48]}, 64'hFFFE);
      repeat (3) cycle();
      chk("t6_sat", {48'b0, cnt_o[63:48]}, 64'hFFFF);
      perf_clr = 1;
      cycle();
      perf_clr = 0;
      chk("t6_clr", cnt_o, 64'h0);
      stall = '0;
      rq[0] = '0;
      rq[1] = '0;
      cycle();
`endif

      // Random traffic; ungranted requests are held unchanged.
      for (int n = 0; n < 400; n++) begin
         for (int i = 0; i < 4; i++)
            if (!(rq[i][32] && !gr[i]))
               rq[i] = {2'($urandom_range(0, 3)), 1'($urandom_range(0, 3) != 0), 32'($urandom)};
         stall = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0;
         cycle();
      end
      for (int i = 0; i < 4; i++) rq[i] = '0;
      stall = '0;
      cycle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/bg_write_arbiter.md
# bg_write_arbiter

Round-robin write arbiter placed in front of the 4x4 LSU-to-bank-group write crossbar. It takes four packed LSU write requests, resolves bank-group conflicts with one fair round-robin arbiter per bank group, and returns a per-LSU ready. Granted requests go into a registered output stage that drives the four bank-group write ports. An LSU that loses arbitration holds its request until it is granted, so the write crossbar no longer silently drops lower-priority writes.

## Interface
Parameters (shared `define` constants, not module parameters):
- `W_Q`, 35: packed LSU write request, `{sel[1:0], wen, data[31:0]}`.
- `W_d`, 33: bank-group write word, `{wen, data[31:0]}`.
- `NUM_LSU`, 4: number of requesters.
- `NUM_BG`, 4: number of bank groups.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: reset, asynchronous and active-high.
- `LSU_W_req_0..3` in `W_Q` each: packed requests. `wen`=1 means the request is valid.
- `LSU_W_ready_0..3` out 1 each: grant/accept for the same cycle.
- `bg_stall` in 4: bit b set blocks all grants to bank group b this cycle.
- `W_BG_0..3` out `W_d` each: registered bank-group write word.
- `perf_clr` in 1: synchronous clear of the conflict counters. Present only with the macro.
- `bg_conflict_cnt` out 64: four 16-bit counters, bank group b at bits [16b+15:16b]. Present only with the macro.

## Operation
- LSU i requests bank group `sel_i` when `wen_i`=1. Each LSU targets at most one bank group per cycle, so it receives at most one grant.
- Each bank group b has a 2-bit pointer `p_b`. Priority order is `p_b`, `p_b+1`, `p_b+2`, `p_b+3`, all mod 4.
- The first valid requester in that order is granted, provided `bg_stall[b]`=0.
- `LSU_W_ready_i` = 1 iff LSU i is granted this cycle.
- A transfer happens when `wen_i` && `LSU_W_ready_i`. A requester that is not granted must hold its request stable until it is granted.
- On a grant to LSU k at bank group b:
  - `W_BG_b` <= `{1'b1, data_k}` at the next edge.
  - `p_b` <= (k+1) mod 4, so 3 wraps to 0.
- If bank group b has no grant (no requester, or stalled):
  - `W_BG_b` <= 0.
  - `p_b` holds.
- The four bank groups arbitrate independently and in the same cycle. Up to 4 grants can be issued per cycle.
- A request with `wen`=0 is ignored regardless of its `sel` value.

## Timing
- Arbitration and ready are combinational from the current requests, `p_b` and `bg_stall`.
- Latency from request to bank-group port is 1 cycle: a request granted in cycle n appears on `W_BG_b` in cycle n+1 for exactly one cycle.
- Values while `rst`=1:
  - All `W_BG_*` are 0.
  - All `p_b` are 0, so LSU0 has first priority.
  - All `LSU_W_ready_*` are 0 (gated by `rst`).
  - All counters are 0.
- Reset mid-operation:
  - Any write in flight in the output register is lost.
  - A requester that was holding re-arbitrates from `p`=0 once reset is released.
- Simultaneous `bg_stall[b]` and a request: no grant, ready stays 0, the request is held.
- A stalled requester keeps holding its request. Its worst-case wait is 3 grant cycles on an unstalled bank group.

## Configuration
- Macro: `BG_WRITE_ARB_PERF_CNT_EN`.
- When defined:
  - Per bank group, a 16-bit counter increments in each cycle where 2 or more valid requests target that bank group, including stalled cycles.
  - Each counter saturates at 16'hFFFF.
  - `perf_clr`=1 zeroes all four counters at the next edge and takes precedence over the increment.
  - The `perf_clr` and `bg_conflict_cnt` ports exist.
- When undefined: the counters, `perf_clr` and `bg_conflict_cnt` are absent. Arbitration behaviour is identical.

## Structure
- `W_Q`, `W_d`, `NUM_LSU`, `NUM_BG` and the request field offsets go in the shared `param_define.v`.
- Sub-module `rr_arbiter_4`:
  - Inputs: 4-bit request vector, 2-bit pointer, stall.
  - Outputs: one-hot grant and the next pointer.
  - Instantiated once per bank group.
- The top level holds:
  - request unpacking;
  - per-bank request-vector build;
  - OR-reduction of grants into the per-LSU ready;
  - the output registers;
  - the optional counters.

## Test plan
- Reset release, then LSU0 sends `{sel=2, wen=1, data=0xA5A5A5A5}` -> `LSU_W_ready_0`=1 the same cycle, `W_BG_2`=0x1A5A5A5A5 the next cycle, all other `W_BG` ports 0.
- All 4 LSUs target bank group 1 and hold their requests -> grants go to LSU0, LSU1, LSU2, LSU3 in consecutive cycles, `p_1` ends at 0, and `W_BG_1` carries each LSU's data in turn.
- LSUs 0-3 target bank groups 3, 2, 1, 0 respectively -> all ready in the same cycle, and all four `W_BG` ports are valid next cycle.
- `bg_stall`=4'b0001 with LSU2 on bank group 0 for 3 cycles, then `bg_stall` clears -> ready stays 0 for 3 cycles, then the grant, then `W_BG_0` valid.
- `rst` asserted the cycle after a grant -> `W_BG` ports immediately 0, and the next arbitration on that bank group favours LSU0.
- With `BG_WRITE_ARB_PERF_CNT_EN`: LSU0 and LSU1 both on bank group 3 for 5 cycles -> `bg_conflict_cnt`[63:48]=5. A preload of 0xFFFE plus 3 conflict cycles saturates at 0xFFFF. `perf_clr` -> 0.
